switch_debounce: RTL
====================

Name: switch_debounce

Overview:
- Conditions one raw push-button input before edge-detecting logic such as LED toggle and counter blocks consume it.
- Synchronises the asynchronous pin to i_Clk and filters contact bounce with a stability counter.
- Outputs a clean level, single-cycle press and release strobes, and a one-shot long-press strobe.
- Downstream blocks use o_Release directly instead of building their own edge detector.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clocks required to accept a new level (10 ms at 25 MHz); legal range is 1 or more.
- LONG_PRESS_CYCLES, 25000000, clocks the debounced level must stay high before o_Long_Press fires (1 s at 25 MHz); legal range is 1 or more.

Ports:
- i_Clk  input  1  system clock; all state updates on its rising edge.
- i_Rst  input  1  asynchronous, active-high reset.
- i_Switch  input  1  raw switch pin, asynchronous to i_Clk; 1 = pressed.
- o_Switch  output  1  debounced switch level.
- o_Press  output  1  one-cycle strobe on a debounced 0->1 transition.
- o_Release  output  1  one-cycle strobe on a debounced 1->0 transition.
- o_Long_Press  output  1  one-cycle strobe when the press has been held LONG_PRESS_CYCLES.

Behaviour:
- Reset:
  - One clock (i_Clk); reset is asynchronous and active-high (i_Rst).
  - While i_Rst is high: both synchroniser flops, the stable level, both counters and all outputs are 0.
  - Deassertion takes effect at the next i_Clk edge.
  - Reset mid-debounce or mid-hold discards all progress; no strobe is generated by reset.
- Synchroniser: two flops, sync1 <= i_Switch and sync2 <= sync1. Only sync2 feeds the filter.
- Debounce counter (width $clog2(DEBOUNCE_CYCLES+1)):
  - Each edge with sync2 == stable: cnt <= 0.
  - Each edge with sync2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - Each edge with sync2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - A single-cycle glitch back to the stable value clears cnt. The restart is complete, with no decrement.
- Latency: let t0 be the first edge sampling i_Switch at its new level, held steady. o_Switch changes after edge t0+DEBOUNCE_CYCLES+1.
- o_Switch = stable, registered.
- Strobe timing:
  - o_Press is high for exactly the one cycle following the edge where stable goes 0->1.
  - o_Release is the same for 1->0.
  - o_Press and o_Release are never both high in the same cycle.
- State machine (encoded via stable plus a hold flag):
  - LOW: stable = 0.
  - HELD: stable = 1, long press not yet signalled.
  - LONG: stable = 1, long press already signalled.
  - LOW->HELD on acceptance of 1.
  - HELD->LONG when hold_cnt reaches LONG_PRESS_CYCLES.
  - HELD or LONG -> LOW on acceptance of 0.
- Hold counter (width $clog2(LONG_PRESS_CYCLES+1)):
  - Cleared to 0 on the edge stable becomes 1.
  - Increments each edge while in HELD.
  - On the edge it becomes LONG_PRESS_CYCLES: o_Long_Press is high for the next cycle only, and the state moves to LONG.
  - Frozen in LONG, so there is no wrap and no repeat strobe.
  - Cleared on entry to LOW.
- Release in HELD before the threshold: o_Release fires and o_Long_Press never fires.
- Release in LONG: o_Release fires normally.
- Bounce during hold: a glitch to 0 shorter than DEBOUNCE_CYCLES does not affect stable, hold_cnt or state.
- No combinational path from i_Switch to any output.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10 unless noted):
- Reset check: assert i_Rst asynchronously with i_Switch=1 held -> all outputs 0 immediately. Release reset at edge e -> o_Switch=1 and o_Press pulse after edge e+5 (sync plus 4).
- Clean press: i_Switch 0->1 sampled at t0, held 20 cycles -> o_Switch rises after t0+5 and o_Press high one cycle. o_Long_Press is high exactly one cycle after t0+15, and not again. Then release at t1 -> o_Release one cycle after t1+5.
- Bounce: i_Switch toggles 1,0,1,1,0,1 every cycle, then holds 1 -> o_Switch rises only 5 clocks after the last 0->1 sample, and exactly one o_Press.
- Short press: press held only 3 clocks -> o_Switch stays 0, no strobes. Press held 8 clocks -> o_Press then o_Release, no o_Long_Press.
- Glitch during hold: in HELD with hold_cnt=5, drive 0 for 2 cycles -> o_Switch stays 1, no o_Release. o_Long_Press still fires at the original edge.
- Reset mid-operation: assert i_Rst with debounce cnt=3, then release with i_Switch=1 -> full 5-clock latency restarts. Separately, set DEBOUNCE_CYCLES=1 -> o_Switch follows sync2 with one-clock delay.

Source files
------------

// File: rtl/switch_debounce.sv
// Purpose: synchronise and debounce one raw push-button; emit level, press/release and long-press strobes.
// Latency: level and press/release strobe appear DEBOUNCE_CYCLES+2 edges after the pin settles (2 sync + filter).
// Backpressure: none; strobes are single-cycle and must be consumed when they occur.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int LONG_PRESS_CYCLES = 25000000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long_Press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES);

    // Accepted level is implied by the state: anything other than LOW means pressed.
    typedef enum logic [1:0] {
        ST_LOW  = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_nxt;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic          w_press_nxt;
    logic          w_release_nxt;
    logic          w_long_nxt;
    logic          w_stable;
    logic          w_accept;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_Switch;
            r_sync2 <= r_sync1;
        end
    end

    // State, counters and registered strobes.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state    <= ST_LOW;
            r_cnt      <= '0;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
        end
    end

    // Stability filter, then next-state / hold counter / strobe decode.
    always_comb begin
        w_stable      = (r_state != ST_LOW);
        w_accept      = 1'b0;
        w_cnt_nxt     = '0;
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;

        // Any sample matching the accepted level restarts the run from zero.
        if (r_sync2 != w_stable) begin
            if (r_cnt == CNT_LAST) begin
                w_accept = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end

        case (r_state)
            ST_LOW: begin
                if (w_accept) begin
                    w_state_nxt = ST_HELD;
                    w_hold_nxt  = '0;
                    w_press_nxt = 1'b1;
                end
            end
            ST_HELD: begin
                // A release accepted on the threshold edge wins: no long press.
                if (w_accept) begin
                    w_state_nxt   = ST_LOW;
                    w_hold_nxt    = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + HW'(1);
                    if (w_hold_nxt == HOLD_LAST) begin
                        w_state_nxt = ST_LONG;
                        w_long_nxt  = 1'b1;
                    end
                end
            end
            ST_LONG: begin
                // Hold counter frozen here so the long-press strobe cannot repeat.
                if (w_accept) begin
                    w_state_nxt   = ST_LOW;
                    w_hold_nxt    = '0;
                    w_release_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_hold_nxt  = '0;
            end
        endcase
    end

    assign o_Switch     = w_stable;
    assign o_Press      = r_press;
    assign o_Release    = r_release;
    assign o_Long_Press = r_long;

endmodule
